register_read_unit: RTL and testbench
=====================================

// Module: register_read_unit
// PURPOSE
//  Read side of the general-purpose register file (R0..R3). Takes single-register
//  read requests or a debug "dump" of all four registers. Presents each word on Bus_1
//  through a registered valid/ready output stage. Sits between the four register
//  units and the Bus_1 consumer (ALU operand path / debug port).
// PARAMETERS
//  word_size  8  width of each register and of Bus_1
// PORTS
//  clk       in   1          system clock; all logic on posedge
//  rst       in   1          synchronous, active-high reset
//  R0_out    in   word_size  current value of R0 (R1_out..R3_out likewise, 4 ports)
//  load_R    in   4          load strobes of R3..R0, bit i = load_Ri (bypass only)
//  Bus_2     in   word_size  data being written into the registers (bypass only)
//  rd_req    in   1          single-read request; sampled only in IDLE
//  rd_sel    in   2          register index for rd_req
//  dump_start in  1          start sequential read of R0,R1,R2,R3; sampled only in IDLE
//  out_ready in   1          consumer accepts Bus_1 this cycle
//  Bus_1     out  word_size  registered read data
//  rd_valid  out  1          Bus_1/rd_idx hold a valid word
//  rd_idx    out  2          index of register currently on Bus_1
//  busy      out  1          high in any state other than IDLE
//  dump_done out  1          one-cycle pulse after R3 of a dump is accepted
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, Bus_1=0, rd_valid=0, rd_idx=0, busy=0, dump_done=0.
//   Overrides every other input. Mid-operation reset aborts: no dump_done, word dropped.
//  FSM states: IDLE, S_HOLD (single read), D_HOLD (dump).
//  IDLE: dump_start=1 -> capture R0, rd_idx=0, rd_valid=1, go D_HOLD.
//   Else rd_req=1 -> capture R[rd_sel], rd_idx=rd_sel, rd_valid=1, go S_HOLD.
//   dump_start has priority over a coincident rd_req; the rd_req is dropped, not queued.
//  Latency: request sampled at edge N -> Bus_1/rd_valid valid after edge N (1 cycle).
//  Capture = value of R_i_out at the capturing edge. Dump words are sampled one at a time
//   as each is captured; there is no snapshot at dump start.
//  S_HOLD: Bus_1, rd_idx and rd_valid are stable while out_ready=0.
//   On out_ready=1 -> rd_valid=0, go IDLE. A new request needs one IDLE cycle first.
//  D_HOLD: Bus_1, rd_idx and rd_valid are stable while out_ready=0.
//   On out_ready=1 with rd_idx<3 -> capture R[rd_idx+1] and increment rd_idx; rd_valid stays 1.
//    This gives back-to-back words, one per cycle, when out_ready is held high.
//   On out_ready=1 with rd_idx==3 -> rd_valid=0, dump_done=1 for one cycle, go IDLE.
//  rd_req and dump_start are ignored while busy=1.
//  dump_done is 0 in every cycle other than the pulse. rd_idx does not wrap past 3.
//  Bus_1 keeps its last value after acceptance; consumers qualify it with rd_valid.
// CONFIGURATION
//  READ_BYPASS_EN defined: at a capturing edge, if load_R[i]=1 for the register being
//   captured, the captured word is Bus_2 (the value being written), not R_i_out.
//  Not defined: the captured word is always R_i_out (the pre-write value).
//   load_R and Bus_2 are unused.
// TESTING
//  T1 reset: drive requests during rst=1 -> all outputs 0, busy=0 for all rst cycles.
//  T2 single read: R2=8'hA5, rd_req=1, rd_sel=2, out_ready=0 for 3 cycles, then 1
//   -> Bus_1=A5, rd_idx=2, rd_valid=1 held stable, rd_valid=0 and busy=0 after accept.
//  T3 dump, full speed: R0..R3=11,22,33,44, dump_start=1, out_ready=1
//   -> Bus_1=11,22,33,44 on 4 consecutive cycles, then dump_done=1 for exactly 1 cycle.
//  T4 dump with stall plus priority: dump_start=1 and rd_req=1 on the same cycle;
//   out_ready=0 while rd_idx=1 -> dump sequence taken, word 22 held, rd_req dropped,
//   R1 change during the stall not reflected.
//  T5 bypass: R1=8'h10, load_R=4'b0010, Bus_2=8'h77 on the capturing edge of a read of R1
//   -> Bus_1=77 with READ_BYPASS_EN, 10 without.
//  T6 abort: rst=1 while D_HOLD with rd_idx=2 -> next cycle IDLE, rd_valid=0, no dump_done;
//   a fresh dump after reset starts at R0.

Source files
------------

// File: rtl/register_read_unit.sv
`default_nettype none
// ============================================================================
// Module   : register_read_unit
// Purpose  : Read side of the R0..R3 general-purpose register file. Accepts
//            single-register read requests or a debug dump of all four
//            registers and presents each word on Bus_1 through a registered
//            valid/ready output stage.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            R0_out..R3_out    - current register values
//            load_R, Bus_2     - register write strobes / write data (bypass)
//            rd_req, rd_sel    - single-read request and register index
//            dump_start        - start sequential read of R0..R3
//            out_ready         - consumer accepts Bus_1 this cycle
//            Bus_1, rd_valid,
//            rd_idx            - registered read word, valid flag, its index
//            busy              - high whenever not IDLE
//            dump_done         - one-cycle pulse after R3 of a dump is taken
// Config   : READ_BYPASS_EN - when defined, a register being written on the
//            capturing edge yields Bus_2 instead of its pre-write value.
// Revision : 1.0 - initial release
// ============================================================================
module register_read_unit #(
  parameter int word_size = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [word_size-1:0] R0_out,
  input  logic [word_size-1:0] R1_out,
  input  logic [word_size-1:0] R2_out,
  input  logic [word_size-1:0] R3_out,
  input  logic [3:0]           load_R,
  input  logic [word_size-1:0] Bus_2,
  input  logic                 rd_req,
  input  logic [1:0]           rd_sel,
  input  logic                 dump_start,
  input  logic                 out_ready,
  output logic [word_size-1:0] Bus_1,
  output logic                 rd_valid,
  output logic [1:0]           rd_idx,
  output logic                 busy,
  output logic                 dump_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    S_HOLD = 2'd1,
    D_HOLD = 2'd2
  } state_t;

  state_t               state;
  logic [1:0]           cap_idx;
  logic [word_size-1:0] raw_word;
  logic [word_size-1:0] cap_word;

  // Index of the register that would be captured at the coming edge. In
  // D_HOLD the +1 wraps at rd_idx==3, but no capture happens in that case.
  always_comb begin
    cap_idx = rd_idx + 2'd1;
    if (state == IDLE) begin
      cap_idx = dump_start ? 2'd0 : rd_sel;
    end
  end

  always_comb begin
    raw_word = R0_out;
    case (cap_idx)
      2'd0:    raw_word = R0_out;
      2'd1:    raw_word = R1_out;
      2'd2:    raw_word = R2_out;
      default: raw_word = R3_out;
    endcase
  end

`ifdef READ_BYPASS_EN
  // Forward the word being written so the reader sees the post-write value.
  always_comb begin
    cap_word = raw_word;
    if (load_R[cap_idx]) begin
      cap_word = Bus_2;
    end
  end
`else
  assign cap_word = raw_word;

  logic unused_bypass;
  assign unused_bypass = ^{load_R, Bus_2};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      Bus_1     <= '0;
      rd_valid  <= 1'b0;
      rd_idx    <= 2'd0;
      busy      <= 1'b0;
      dump_done <= 1'b0;
    end else begin
      dump_done <= 1'b0;
      case (state)
        IDLE: begin
          // dump_start wins; a coincident rd_req is dropped.
          if (dump_start) begin
            Bus_1    <= cap_word;
            rd_idx   <= 2'd0;
            rd_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= D_HOLD;
          end else if (rd_req) begin
            Bus_1    <= cap_word;
            rd_idx   <= rd_sel;
            rd_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        D_HOLD: begin
          if (out_ready) begin
            if (rd_idx != 2'd3) begin
              // Next word is sampled now, giving one word per cycle.
              Bus_1  <= cap_word;
              rd_idx <= rd_idx + 2'd1;
            end else begin
              rd_valid  <= 1'b0;
              dump_done <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          rd_valid <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_register_read_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_read_unit
// Purpose  : Directed bench for register_read_unit with a queue-based
//            reference model compared every cycle, plus literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_read_unit;

  logic       clk;
  logic       rst;
  logic [7:0] r0, r1, r2, r3;
  logic [3:0] load_R;
  logic [7:0] bus2;
  logic       rd_req;
  logic [1:0] rd_sel;
  logic       dump_start;
  logic       out_ready;
  logic [7:0] bus1;
  logic       rd_valid;
  logic [1:0] rd_idx;
  logic       busy;
  logic       dump_done;

  int vectors = 0;
  int miscompares = 0;

  register_read_unit #(.word_size(8)) dut (
    .clk(clk), .rst(rst),
    .R0_out(r0), .R1_out(r1), .R2_out(r2), .R3_out(r3),
    .load_R(load_R), .Bus_2(bus2),
    .rd_req(rd_req), .rd_sel(rd_sel), .dump_start(dump_start),
    .out_ready(out_ready),
    .Bus_1(bus1), .rd_valid(rd_valid), .rd_idx(rd_idx),
    .busy(busy), .dump_done(dump_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // The outstanding work is a queue of register indices still to be
  // delivered; the head of the queue is the word currently presented.
  int         q[$];
  logic       m_dump;
  logic [7:0] m_bus;
  logic       m_valid;
  logic [1:0] m_idx;
  logic       m_done;
  logic       started = 1'b0;

  function automatic logic [7:0] capture(int i);
    logic [7:0] v;
    case (i)
      0: v = r0;
      1: v = r1;
      2: v = r2;
      default: v = r3;
    endcase
`ifdef READ_BYPASS_EN
    if (load_R[i]) v = bus2;
`endif
    return v;
  endfunction

  always @(posedge clk) begin
    started = 1'b1;
    m_done  = 1'b0;
    if (rst) begin
      q.delete();
      m_dump  = 1'b0;
      m_bus   = 8'h00;
      m_valid = 1'b0;
      m_idx   = 2'd0;
    end else if (q.size() == 0) begin
      if (dump_start) begin
        for (int k = 0; k < 4; k++) q.push_back(k);
        m_dump = 1'b1;
      end else if (rd_req) begin
        q.push_back(int'(rd_sel));
        m_dump = 1'b0;
      end
      if (q.size() != 0) begin
        m_idx   = 2'(q[0]);
        m_bus   = capture(q[0]);
        m_valid = 1'b1;
      end
    end else if (out_ready) begin
      void'(q.pop_front());
      if (q.size() != 0) begin
        m_idx = 2'(q[0]);
        m_bus = capture(q[0]);
      end else begin
        m_valid = 1'b0;
        m_done  = m_dump;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle after the first edge the DUT must match the model.
  always @(negedge clk) begin
    if (started) begin
      check("bus1",      32'(bus1),      32'(m_bus));
      check("rd_valid",  32'(rd_valid),  32'(m_valid));
      check("rd_idx",    32'(rd_idx),    32'(m_idx));
      check("busy",      32'(busy),      32'(q.size() != 0));
      check("dump_done", 32'(dump_done), 32'(m_done));
    end
  end

  // Hand-computed expectation checked against both DUT and model.
  task automatic lit(input string name, input logic [31:0] dut_v,
                     input logic [31:0] mdl_v, input logic [31:0] exp);
    check(name, dut_v, exp);
    check({name, "_model"}, mdl_v, exp);
  endtask

  task automatic expect_word(input string name, input logic [7:0] w, input logic [1:0] idx);
    lit({name, "_bus"},   32'(bus1),     32'(m_bus),   32'(w));
    lit({name, "_idx"},   32'(rd_idx),   32'(m_idx),   32'(idx));
    lit({name, "_valid"}, 32'(rd_valid), 32'(m_valid), 32'd1);
    lit({name, "_busy"},  32'(busy),     32'(q.size() != 0), 32'd1);
    lit({name, "_done"},  32'(dump_done), 32'(m_done), 32'd0);
  endtask

  task automatic expect_idle(input string name, input logic done);
    lit({name, "_valid"}, 32'(rd_valid),  32'(m_valid), 32'd0);
    lit({name, "_busy"},  32'(busy),      32'(q.size() != 0), 32'd0);
    lit({name, "_done"},  32'(dump_done), 32'(m_done),  32'(done));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] t5_exp;

    // T1: requests asserted during reset must have no effect.
    rst = 1'b1; rd_req = 1'b1; rd_sel = 2'd2; dump_start = 1'b1; out_ready = 1'b0;
    load_R = 4'b0000; bus2 = 8'h00;
    r0 = 8'h01; r1 = 8'h02; r2 = 8'h03; r3 = 8'h04;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      lit("t1_bus", 32'(bus1), 32'(m_bus), 32'd0);
      lit("t1_idx", 32'(rd_idx), 32'(m_idx), 32'd0);
      expect_idle("t1", 1'b0);
    end
    rst = 1'b0; rd_req = 1'b0; dump_start = 1'b0;
    @(negedge clk);

    // T2: single read of R2 held for three stalled cycles.
    r2 = 8'hA5; rd_req = 1'b1; rd_sel = 2'd2;
    @(negedge clk);
    rd_req = 1'b0;
    expect_word("t2_c1", 8'hA5, 2'd2);
    dump_start = 1'b1; r2 = 8'h5A;   // ignored while busy
    @(negedge clk);
    dump_start = 1'b0;
    expect_word("t2_c2", 8'hA5, 2'd2);
    @(negedge clk);
    expect_word("t2_c3", 8'hA5, 2'd2);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    expect_idle("t2_acc", 1'b0);
    lit("t2_bus_kept", 32'(bus1), 32'(m_bus), 32'hA5);
    @(negedge clk);

    // T3: full-speed dump.
    r0 = 8'h11; r1 = 8'h22; r2 = 8'h33; r3 = 8'h44;
    dump_start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    expect_word("t3_w0", 8'h11, 2'd0);
    @(negedge clk); expect_word("t3_w1", 8'h22, 2'd1);
    @(negedge clk); expect_word("t3_w2", 8'h33, 2'd2);
    @(negedge clk); expect_word("t3_w3", 8'h44, 2'd3);
    @(negedge clk); expect_idle("t3_end", 1'b1);
    out_ready = 1'b0;
    @(negedge clk); expect_idle("t3_after", 1'b0);

    // T4: dump beats a coincident read; stall on word 1 while R1 changes.
    dump_start = 1'b1; rd_req = 1'b1; rd_sel = 2'd3; out_ready = 1'b1;
    @(negedge clk);
    dump_start = 1'b0; rd_req = 1'b0;
    expect_word("t4_w0", 8'h11, 2'd0);
    @(negedge clk);
    expect_word("t4_w1", 8'h22, 2'd1);
    out_ready = 1'b0; r1 = 8'h99;
    @(negedge clk); expect_word("t4_stall1", 8'h22, 2'd1);
    @(negedge clk); expect_word("t4_stall2", 8'h22, 2'd1);
    out_ready = 1'b1;
    @(negedge clk); expect_word("t4_w2", 8'h33, 2'd2);
    @(negedge clk); expect_word("t4_w3", 8'h44, 2'd3);
    @(negedge clk); expect_idle("t4_end", 1'b1);
    out_ready = 1'b0;
    @(negedge clk);

    // T5: read of R1 while R1 is being written.
    r1 = 8'h10; load_R = 4'b0010; bus2 = 8'h77; rd_req = 1'b1; rd_sel = 2'd1;
    @(negedge clk);
    rd_req = 1'b0; load_R = 4'b0000;
`ifdef READ_BYPASS_EN
    t5_exp = 8'h77;
`else
    t5_exp = 8'h10;
`endif
    expect_word("t5_bypass", t5_exp, 2'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    expect_idle("t5_acc", 1'b0);
    @(negedge clk);
    // A write to a different register never affects the read.
    load_R = 4'b0001; rd_req = 1'b1; rd_sel = 2'd1;
    @(negedge clk);
    rd_req = 1'b0; load_R = 4'b0000;
    expect_word("t5_other", 8'h10, 2'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);

    // T6: reset while word 2 of a dump is presented.
    r1 = 8'h22;
    dump_start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    expect_word("t6_w2", 8'h33, 2'd2);
    out_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expect_idle("t6_rst", 1'b0);
    lit("t6_idx", 32'(rd_idx), 32'(m_idx), 32'd0);
    lit("t6_bus", 32'(bus1), 32'(m_bus), 32'd0);
    @(negedge clk);
    expect_idle("t6_nodone", 1'b0);
    dump_start = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    expect_word("t6_fresh", 8'h11, 2'd0);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    expect_idle("t6_end", 1'b1);
    out_ready = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
